data_ram_port_arbiter: RTL and testbench

//  Shares the data RAM write port and read port 1 between the MiniAlu core and a host requester (debug/loader).
//  The core owns the RAM by default. The host gets single-cycle slots in two cases: when the core is idle
//  (NOP), or when the host has waited MAX_WAIT cycles (forced slot).

---
 rtl/data_ram_port_arbiter_pkg.sv | 14 +
 rtl/data_ram_port_arbiter_ram_port_mux.sv | 25 ++
 rtl/data_ram_port_arbiter.sv | 123 ++++++++++++
 tb/tb_data_ram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_port_arbiter_pkg.sv
// rtl/data_ram_port_arbiter_pkg.sv - shared state encodings and sizing helper for the data RAM arbiter
package data_ram_port_arbiter_pkg;

   typedef enum logic {
      ARB_S_CORE = 1'b0,
      ARB_S_HOST = 1'b1
   } arb_state_e;

   // Counter width that stays legal when the count range collapses to a single value.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/data_ram_port_arbiter_ram_port_mux.sv
// rtl/data_ram_port_arbiter_ram_port_mux.sv - 2:1 select of RAM write port and read port 1 between core and host
module data_ram_port_arbiter_ram_port_mux #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  host_sel_i,
   input  logic                  core_we_i,
   input  logic [ADDR_WIDTH-1:0] core_waddr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   input  logic [ADDR_WIDTH-1:0] core_raddr_i,
   input  logic                  host_we_i,
   input  logic [ADDR_WIDTH-1:0] host_addr_i,
   input  logic [DATA_WIDTH-1:0] host_wdata_i,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_waddr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic [ADDR_WIDTH-1:0] ram_raddr_o
);

   assign ram_we_o    = host_sel_i ? host_we_i    : core_we_i;
   assign ram_waddr_o = host_sel_i ? host_addr_i  : core_waddr_i;
   assign ram_wdata_o = host_sel_i ? host_wdata_i : core_wdata_i;
   assign ram_raddr_o = host_sel_i ? host_addr_i  : core_raddr_i;

endmodule

// File: rtl/data_ram_port_arbiter.sv
// rtl/data_ram_port_arbiter.sv - shares data RAM write port and read port 1 between core and host requester
module data_ram_port_arbiter
   import data_ram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_WAIT   = 4,
   parameter int HOST_BURST = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iCoreIdle,
   input  logic                  iCoreWriteEnable,
   input  logic [ADDR_WIDTH-1:0] iCoreWriteAddress,
   input  logic [DATA_WIDTH-1:0] iCoreDataIn,
   input  logic [ADDR_WIDTH-1:0] iCoreReadAddress1,
   output logic                  oCoreStall,
   input  logic                  iHostReq,
   input  logic                  iHostWrite,
   input  logic [ADDR_WIDTH-1:0] iHostAddress,
   input  logic [DATA_WIDTH-1:0] iHostData,
   output logic                  oHostGrant,
   output logic                  oHostValid,
   output logic [DATA_WIDTH-1:0] oHostData,
   output logic                  oRamWriteEnable,
   output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
   output logic [DATA_WIDTH-1:0] oRamDataIn,
   output logic [ADDR_WIDTH-1:0] oRamReadAddress1,
   input  logic [DATA_WIDTH-1:0] iRamDataOut1
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = cnt_width(HOST_BURST);

   arb_state_e            state_q, state_d;
   logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
   logic                  host_valid_q, host_valid_d;
   logic [DATA_WIDTH-1:0] host_data_q, host_data_d;
   logic                  slot_live;
   logic                  host_rd;
   logic                  mux_we;

   // A reset arriving mid-slot hands the port straight back and kills any host access that cycle.
   assign slot_live = (state_q == ARB_S_HOST) && !Reset;
   assign host_rd   = slot_live && iHostReq && !iHostWrite;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      burst_cnt_d  = burst_cnt_q;
      host_valid_d = host_rd;
      host_data_d  = host_data_q;
      if (host_rd) begin
         host_data_d = iRamDataOut1;
      end
      case (state_q)
         ARB_S_CORE: begin
            if (iHostReq && (iCoreIdle || wait_cnt_q == WW'(MAX_WAIT))) begin
               state_d     = ARB_S_HOST;
               burst_cnt_d = '0;
               wait_cnt_d  = '0;
            end else if (iHostReq) begin
               if (wait_cnt_q != WW'(MAX_WAIT)) begin
                  wait_cnt_d = wait_cnt_q + WW'(1);
               end
            end else begin
               wait_cnt_d = '0;
            end
         end
         ARB_S_HOST: begin
            if (iHostReq && (burst_cnt_q < BW'(HOST_BURST - 1))) begin
               burst_cnt_d = burst_cnt_q + BW'(1);
            end else begin
               state_d    = ARB_S_CORE;
               wait_cnt_d = '0;
            end
         end
         default: state_d = ARB_S_CORE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= ARB_S_CORE;
         wait_cnt_q   <= '0;
         burst_cnt_q  <= '0;
         host_valid_q <= 1'b0;
         host_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         burst_cnt_q  <= burst_cnt_d;
         host_valid_q <= host_valid_d;
         host_data_q  <= host_data_d;
      end
   end

   data_ram_port_arbiter_ram_port_mux #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram_port_mux (
      .host_sel_i  (slot_live),
      .core_we_i   (iCoreWriteEnable),
      .core_waddr_i(iCoreWriteAddress),
      .core_wdata_i(iCoreDataIn),
      .core_raddr_i(iCoreReadAddress1),
      .host_we_i   (iHostReq && iHostWrite),
      .host_addr_i (iHostAddress),
      .host_wdata_i(iHostData),
      .ram_we_o    (mux_we),
      .ram_waddr_o (oRamWriteAddress),
      .ram_wdata_o (oRamDataIn),
      .ram_raddr_o (oRamReadAddress1)
   );

   assign oRamWriteEnable = mux_we && !Reset;
   assign oCoreStall      = slot_live;
   assign oHostGrant      = slot_live && iHostReq;
   assign oHostValid      = host_valid_q;
   assign oHostData       = host_data_q;

endmodule

// File: tb/tb_data_ram_port_arbiter.sv
// tb/tb_data_ram_port_arbiter.sv - directed and randomized self-checking bench for data_ram_port_arbiter
module tb_data_ram_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int MW = 4;
   localparam int HB = 2;

   logic          clk = 1'b0;
   logic          Reset;
   logic          iCoreIdle, iCoreWriteEnable;
   logic [AW-1:0] iCoreWriteAddress, iCoreReadAddress1;
   logic [DW-1:0] iCoreDataIn;
   logic          oCoreStall;
   logic          iHostReq, iHostWrite;
   logic [AW-1:0] iHostAddress;
   logic [DW-1:0] iHostData;
   logic          oHostGrant, oHostValid;
   logic [DW-1:0] oHostData;
   logic          oRamWriteEnable;
   logic [AW-1:0] oRamWriteAddress, oRamReadAddress1;
   logic [DW-1:0] oRamDataIn, iRamDataOut1;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   data_ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW), .HOST_BURST(HB)) dut (
      .Clock(clk), .Reset(Reset),
      .iCoreIdle(iCoreIdle), .iCoreWriteEnable(iCoreWriteEnable),
      .iCoreWriteAddress(iCoreWriteAddress), .iCoreDataIn(iCoreDataIn),
      .iCoreReadAddress1(iCoreReadAddress1), .oCoreStall(oCoreStall),
      .iHostReq(iHostReq), .iHostWrite(iHostWrite), .iHostAddress(iHostAddress),
      .iHostData(iHostData), .oHostGrant(oHostGrant), .oHostValid(oHostValid),
      .oHostData(oHostData), .oRamWriteEnable(oRamWriteEnable),
      .oRamWriteAddress(oRamWriteAddress), .oRamDataIn(oRamDataIn),
      .oRamReadAddress1(oRamReadAddress1), .iRamDataOut1(iRamDataOut1)
   );

   // Environment RAM driven by the DUT's RAM-side outputs.
   logic [DW-1:0] ram [0:255];
   assign iRamDataOut1 = ram[oRamReadAddress1];
   always @(posedge clk) if (oRamWriteEnable) ram[oRamWriteAddress] <= oRamDataIn;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: who owns the RAM this cycle, how long the host has waited,
   // how many host slots the current episode has used, and what the RAM should hold.
   int            host_run = -1;
   int            waited = 0;
   int            stall_run = 0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic [DW-1:0] shadow [0:255];

   always @(negedge clk) begin
      logic e_stall, e_grant, e_we, n_valid;
      logic [AW-1:0] e_waddr, e_raddr;
      logic [DW-1:0] e_wdata, n_data;
      if (chk_en) begin
         e_stall = 1'b0; e_grant = 1'b0;
         e_we = iCoreWriteEnable; e_waddr = iCoreWriteAddress;
         e_wdata = iCoreDataIn; e_raddr = iCoreReadAddress1;
         n_valid = 1'b0; n_data = m_data;
         if (Reset) begin
            e_we = 1'b0;
            n_data = '0;
         end else if (host_run >= 0) begin
            e_stall = 1'b1; e_grant = iHostReq;
            e_we = iHostReq && iHostWrite; e_waddr = iHostAddress;
            e_wdata = iHostData; e_raddr = iHostAddress;
            if (iHostReq && !iHostWrite) begin
               n_valid = 1'b1;
               n_data = shadow[iHostAddress];
            end
         end
         chk("stall", oCoreStall, e_stall);
         chk("grant", oHostGrant, e_grant);
         chk("ram_we", oRamWriteEnable, e_we);
         chk("ram_raddr", oRamReadAddress1, e_raddr);
         if (e_we) begin
            chk("ram_waddr", oRamWriteAddress, e_waddr);
            chk("ram_wdata", oRamDataIn, e_wdata);
         end
         chk("host_valid", oHostValid, m_valid);
         chk("host_data", oHostData, m_data);
         stall_run = oCoreStall ? stall_run + 1 : 0;
         chk("stall_run_bound", 32'(stall_run <= HB), 32'd1);

         if (e_we) shadow[e_waddr] = e_wdata;
         m_valid = n_valid;
         m_data = n_data;
         if (Reset) begin
            host_run = -1; waited = 0;
         end else if (host_run < 0) begin
            if (iHostReq && (iCoreIdle || waited == MW)) begin
               host_run = 0; waited = 0;
            end else begin
               waited = iHostReq ? ((waited < MW) ? waited + 1 : MW) : 0;
            end
         end else if (iHostReq && host_run + 1 < HB) begin
            host_run++;
         end else begin
            host_run = -1; waited = 0;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      iHostReq = 1'b0; iCoreIdle = 1'b1; iCoreWriteEnable = 1'b0;
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   // Presents one host op, holds it until granted, then drops the request.
   task automatic host_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int n, output logic rv, output logic [DW-1:0] rd,
                           output logic we_at_grant);
      bit got = 0;
      n = -1; we_at_grant = 1'b0;
      iHostReq = 1'b1; iHostWrite = wr; iHostAddress = a; iHostData = d;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (oHostGrant) begin
            got = 1; n = i; we_at_grant = oRamWriteEnable;
            break;
         end
         next_cycle();
      end
      chk("grant_within_bound", 32'(got), 32'd1);
      next_cycle();
      iHostReq = 1'b0;
      @(negedge clk);
      rv = oHostValid; rd = oHostData;
      next_cycle();
   endtask

   initial begin
      int n;
      logic rv, wg;
      logic [DW-1:0] rd;
      logic [4:0] pat;
      bit g;
      for (int i = 0; i < 256; i++) begin ram[i] = '0; shadow[i] = '0; end
      Reset = 1'b1; iCoreIdle = 1'b1; iCoreWriteEnable = 1'b0;
      iCoreWriteAddress = '0; iCoreDataIn = '0; iCoreReadAddress1 = '0;
      iHostReq = 1'b0; iHostWrite = 1'b0; iHostAddress = '0; iHostData = '0;
      next_cycle();
      chk_en = 1;
      @(negedge clk);
      chk("reset_stall", oCoreStall, 0);
      chk("reset_grant", oHostGrant, 0);
      chk("reset_valid", oHostValid, 0);
      chk("reset_data", oHostData, 0);
      next_cycle();
      Reset = 1'b0;
      idle_cycles(2);

      // Host write while the core is idle.
      host_txn(1'b1, 8'h10, 16'hBEEF, n, rv, rd, wg);
      chk("t1_grant_latency", n, 1);
      chk("t1_we_at_grant", wg, 1);
      chk("t1_no_valid", rv, 0);
      idle_cycles(2);

      // Core preloads RAM[20]; host reads it and the earlier host write back.
      iCoreIdle = 1'b0; iCoreWriteEnable = 1'b1; iCoreWriteAddress = 8'h20; iCoreDataIn = 16'h1234;
      next_cycle();
      idle_cycles(1);
      host_txn(1'b0, 8'h20, 16'h0, n, rv, rd, wg);
      chk("t2_valid", rv, 1);
      chk("t2_data", rd, 16'h1234);
      idle_cycles(1);
      host_txn(1'b0, 8'h10, 16'h0, n, rv, rd, wg);
      chk("t1_readback", rd, 16'hBEEF);
      idle_cycles(2);

      // Core busy and writing throughout: forced slot after MAX_WAIT+1 cycles.
      iCoreIdle = 1'b0; iCoreWriteEnable = 1'b1; iCoreWriteAddress = 8'h30; iCoreDataIn = 16'hAAAA;
      host_txn(1'b0, 8'h40, 16'h0, n, rv, rd, wg);
      chk("t3_forced_latency", n, MW + 1);
      chk("t3_core_write_blocked", wg, 0);
      chk("t3_valid", rv, 1);
      idle_cycles(2);

      // Three back-to-back host writes: two-slot burst, one core cycle, then the third.
      iHostReq = 1'b1; iHostWrite = 1'b1; iHostAddress = 8'h50; iHostData = 16'h5000;
      pat = '0; n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         g = oHostGrant;
         pat = {pat[3:0], g};
         next_cycle();
         if (g) begin
            n++;
            iHostAddress = iHostAddress + 8'd1; iHostData = iHostData + 16'd1;
            if (n == 3) iHostReq = 1'b0;
         end
      end
      chk("t4_grant_pattern", pat, 5'b01101);
      idle_cycles(2);

      // Reset landing on the granted read cycle.
      iHostReq = 1'b1; iHostWrite = 1'b0; iHostAddress = 8'h20;
      next_cycle();
      Reset = 1'b1;
      @(negedge clk);
      chk("t5_grant_in_reset", oHostGrant, 0);
      chk("t5_stall_in_reset", oCoreStall, 0);
      next_cycle();
      Reset = 1'b0; iHostReq = 1'b0;
      @(negedge clk);
      chk("t5_valid_after", oHostValid, 0);
      chk("t5_stall_after", oCoreStall, 0);
      next_cycle();
      idle_cycles(1);

      // Core write with no host traffic passes straight through.
      iCoreIdle = 1'b0; iCoreWriteEnable = 1'b1; iCoreWriteAddress = 8'h05;
      iCoreDataIn = 16'h0F0F; iCoreReadAddress1 = 8'h20;
      @(negedge clk);
      chk("t6_we", oRamWriteEnable, 1);
      chk("t6_waddr", oRamWriteAddress, 8'h05);
      chk("t6_wdata", oRamDataIn, 16'h0F0F);
      chk("t6_rdata", iRamDataOut1, 16'h1234);
      chk("t6_stall", oCoreStall, 0);
      next_cycle();
      idle_cycles(1);

      // Randomized traffic; the host honours hold-until-grant.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         g = oHostGrant;
         next_cycle();
         Reset = ($urandom_range(0, 79) == 0);
         iCoreIdle = $urandom_range(0, 1) == 1;
         iCoreWriteEnable = !iCoreIdle && ($urandom_range(0, 1) == 1);
         iCoreWriteAddress = AW'($urandom_range(0, 15));
         iCoreDataIn = DW'($urandom);
         iCoreReadAddress1 = AW'($urandom_range(0, 15));
         if (!iHostReq || g) begin
            iHostReq = $urandom_range(0, 2) != 0;
            iHostWrite = $urandom_range(0, 1) == 1;
            iHostAddress = AW'($urandom_range(0, 15));
            iHostData = DW'($urandom);
         end
      end
      Reset = 1'b0;
      idle_cycles(3);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
